// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with parameterised width and depth.
// It has programmable almost-full and almost-empty thresholds.
// It supports standard or first-word-fall-through reads.
// Overflow and underflow error flags are sticky.
//
// Ports
//   clk, rst       : clock; synchronous active-high reset
//   wr, in         : write request and write data
//   rd             : read request (in FWFT mode it pops the word shown on out)
//   err_clr        : clears the sticky overflow/underflow flags
//   out            : read data
//   full, empty    : count == DEPTH, count == 0
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   count          : current occupancy
//   overflow       : sticky; a write was attempted while full
//   underflow      : sticky; a read was attempted while empty
//
// Port names are kept unsuffixed so a checker module can bind with .*.
module sync_fifo_param #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    parameter  bit FWFT     = 1'b0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Acceptance uses the flags from the start of the cycle.
    // A read at full therefore never makes room for a same-cycle write.
    // A write at empty never feeds a same-cycle read.
    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A set event beats a simultaneous clear, so no error is lost.
    always_comb begin
        ovf_d = err_clr ? 1'b0 : ovf_q;
        unf_d = err_clr ? 1'b0 : unf_q;
        if (wr && full)  ovf_d = 1'b1;
        if (rd && empty) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset.
    // Stale entries are unreachable once the pointers return to zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= in;
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is presented combinationally.
            // It is forced to zero while empty so stale data never leaks out.
            assign out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (rst)         out_q <= '0;
                else if (rd_acc) out_q <= mem_q[rd_ptr_q];
            end
            assign out = out_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
